bin2bcd_seq: RTL

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, with parametrised binary width and BCD digit count. It converts one binary value per request over BIN_W clock cycles using a start/done handshake. It sits between the vending controller's binary credit and price arithmetic and the 7-segment display drivers, and replaces per-digit combinational correction chains with one iterated correction stage.

---
 rtl/bin2bcd_seq.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Define BIN2BCD_SAT_EN to force bcd to all nines whenever the value overflows DIGITS.
module bin2bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [BIN_W-1:0]    bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic                overflow
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;

  logic [BIN_W-1:0]   sh_q, sh_d;
  logic [BCD_W-1:0]   scr_q, scr_d;
  logic               sticky_q, sticky_d;

  logic [BCD_W-1:0]   scr_corr;
  logic [BCD_W-1:0]   scr_nx;
  logic [BIN_W-1:0]   sh_nx;
  logic               carry_out;
  logic               sticky_nx;
  logic               last_iter;

  // Digits above 9 never occur in a legal scratch register, so their mapping is left open.
  function automatic logic [3:0] add3(input logic [3:0] d);
    logic [3:0] r;
    if (d <= 4'd4)      r = d;
    else if (d <= 4'd9) r = d + 4'd3;
    else                r = 'x;
    return r;
  endfunction

`ifdef BIN2BCD_SAT_EN
  function automatic logic [BCD_W-1:0] saturate(input logic [BCD_W-1:0] v, input logic ovf);
    return ovf ? {DIGITS{4'h9}} : v;
  endfunction
`endif

  always_comb begin
    scr_corr = '0;
    for (int i = 0; i < DIGITS; i++) begin
      scr_corr[4*i +: 4] = add3(scr_q[4*i +: 4]);
    end
  end

  // The bit leaving the top digit means the running value reached 10^DIGITS.
  assign carry_out = scr_corr[BCD_W-1];
  assign scr_nx    = {scr_corr[BCD_W-2:0], sh_q[BIN_W-1]};
  assign sh_nx     = sh_q << 1;
  assign sticky_nx = sticky_q | carry_out;
  assign last_iter = (cnt_q == CNT_W'(BIN_W - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    bcd_d    = bcd_q;
    ovf_d    = ovf_q;
    sh_d     = sh_q;
    scr_d    = scr_q;
    sticky_d = sticky_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SHIFT;
          cnt_d    = '0;
          busy_d   = 1'b1;
          sh_d     = bin;
          scr_d    = '0;
          sticky_d = 1'b0;
        end
      end
      SHIFT: begin
        cnt_d    = cnt_q + CNT_W'(1);
        busy_d   = 1'b1;
        sh_d     = sh_nx;
        scr_d    = scr_nx;
        sticky_d = sticky_nx;
        if (last_iter) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          ovf_d   = sticky_nx;
`ifdef BIN2BCD_SAT_EN
          bcd_d   = saturate(scr_nx, sticky_nx);
`else
          bcd_d   = scr_nx;
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and visible outputs: reset to a clean idle state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  // Working datapath: always reloaded on acceptance, so no reset needed.
  always_ff @(posedge clk) begin
    sh_q     <= sh_d;
    scr_q    <= scr_d;
    sticky_q <= sticky_d;
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = ovf_q;

endmodule
